// File: rtl/prio_arb_rr.sv
// Registered N-way arbiter with runtime fixed-priority / round-robin mode.
// A grant is held until acked or withdrawn by its requester.

module prio_arb_rr_lane #(
    parameter int IW  = 2,
    parameter int IDX = 0
) (
    input  logic [IW-1:0] start,
    input  logic          req,
    output logic          hi_req
);
    // Request at or above the round-robin start position.
    assign hi_req = req & (IW'(IDX) >= start);
endmodule

module prio_arb_rr #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          mode,
    input  logic          ack,
    output logic [IW-1:0] gnt_idx,
    output logic [N-1:0]  gnt_oh,
    output logic          valid
);
    typedef struct packed {
        logic          valid;
        logic [IW-1:0] idx;
        logic [N-1:0]  oh;
    } grant_t;

    logic [IW-1:0] ptr;
    logic [IW-1:0] idx_inc;
    logic [IW-1:0] start;
    logic [N-1:0]  hi_req;
    logic [IW-1:0] pick;
    logic          hold;
    logic          rel;
    grant_t        nxt;

    function automatic logic [IW-1:0] lowest(input logic [N-1:0] v);
        lowest = '0;
        for (int i = N - 1; i >= 0; i--)
            if (v[i]) lowest = IW'(i);
    endfunction

    assign hold    = valid & ~ack & req[gnt_idx];
    assign rel     = valid & ack;
    // Explicit wrap so non-power-of-two N never yields an index >= N.
    assign idx_inc = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    assign start   = rel ? idx_inc : ptr;

    for (genvar i = 0; i < N; i++) begin : g_lane
        prio_arb_rr_lane #(.IW(IW), .IDX(i)) u_lane (
            .start  (start),
            .req    (req[i]),
            .hi_req (hi_req[i])
        );
    end

    // Round-robin: first request at/after start, else wrap to lowest overall.
    always_comb begin
        pick = lowest(req);
        if (mode && |hi_req) pick = lowest(hi_req);
        nxt = '0;
        if (|req) begin
            nxt.valid = 1'b1;
            nxt.idx   = pick;
            nxt.oh    = N'(1) << pick;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            gnt_idx <= '0;
            gnt_oh  <= '0;
            ptr     <= '0;
        end else if (!hold) begin
            valid   <= nxt.valid;
            gnt_idx <= nxt.idx;
            gnt_oh  <= nxt.oh;
            if (rel) ptr <= idx_inc;
        end
    end
endmodule

// File: tb/tb_prio_arb_rr.sv
// Directed + random check of prio_arb_rr (N=4) against a scan-based reference model.

module tb_prio_arb_rr;
    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic          mode;
    logic          ack;
    logic [IW-1:0] gnt_idx;
    logic [N-1:0]  gnt_oh;
    logic          valid;

    int n_asserts = 0;
    int n_fail    = 0;

    // reference model state
    bit m_valid;
    int m_idx;
    int m_ptr;

    prio_arb_rr #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .mode    (mode),
        .ack     (ack),
        .gnt_idx (gnt_idx),
        .gnt_oh  (gnt_oh),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int scan(input logic [N-1:0] r, input int st, input bit m);
        int s;
        s = m ? st : 0;
        for (int k = 0; k < N; k++)
            if (r[(s + k) % N]) return (s + k) % N;
        return -1;
    endfunction

    task automatic model_edge(input bit r_rst, input logic [N-1:0] r, input bit m, input bit a);
        int w;
        if (r_rst) begin
            m_valid = 0; m_idx = 0; m_ptr = 0;
        end else if (!(m_valid && !a && r[m_idx])) begin
            if (m_valid && a) m_ptr = (m_idx + 1) % N;
            w = scan(r, m_ptr, m);
            m_valid = (w >= 0);
            m_idx   = (w >= 0) ? w : 0;
        end
    endtask

    task automatic step(input bit r_rst, input logic [N-1:0] r, input bit m, input bit a);
        logic [N-1:0] exp_oh;
        rst = r_rst; req = r; mode = m; ack = a;
        @(posedge clk);
        model_edge(r_rst, r, m, a);
        #1;
        exp_oh = m_valid ? (N'(1) << m_idx) : '0;
        chk("model_valid", 64'(valid), 64'(m_valid));
        chk("model_idx", 64'(gnt_idx), 64'(m_idx));
        chk("model_oh", 64'(gnt_oh), 64'(exp_oh));
    endtask

    task automatic exp_grant(input string tag, input int e);
        chk({tag, "_valid"}, 64'(valid), 64'd1);
        chk({tag, "_idx"}, 64'(gnt_idx), 64'(e));
    endtask

    task automatic exp_idle(input string tag);
        chk({tag, "_valid"}, 64'(valid), 64'd0);
        chk({tag, "_idx"}, 64'(gnt_idx), 64'd0);
        chk({tag, "_oh"}, 64'(gnt_oh), 64'd0);
    endtask

    logic [N-1:0] fx_req [9] = '{4'b1000, 4'b1100, 4'b0100, 4'b1010, 4'b1110,
                                 4'b1111, 4'b0111, 4'b0011, 4'b0000};
    int           fx_idx [8] = '{3, 2, 2, 1, 1, 0, 0, 0};
    int           rr_seq [6] = '{0, 1, 2, 3, 0, 1};
    int           wr_seq [4] = '{3, 0, 3, 0};

    initial begin
        rst = 1'b1; req = '0; mode = 1'b0; ack = 1'b0;
        m_valid = 0; m_idx = 0; m_ptr = 0;

        // reset with all requests active
        step(1, 4'b1111, 0, 0);
        step(1, 4'b1111, 0, 0);
        exp_idle("reset");

        // fixed priority, legacy encoder patterns
        for (int i = 0; i < 9; i++) begin
            step(0, fx_req[i], 0, 1);
            if (i < 8) exp_grant("fixed", fx_idx[i]);
            else       exp_idle("fixed_none");
        end

        // reset while a grant is held
        step(0, 4'b0110, 1, 0);
        step(0, 4'b0110, 1, 0);
        step(1, 4'b0110, 1, 0);
        exp_idle("reset_hold");

        // hold for 5 cycles, then two acks
        for (int i = 0; i < 5; i++) begin
            step(0, 4'b0110, 1, 0);
            exp_grant("hold", 1);
        end
        step(0, 4'b0110, 1, 1);
        exp_grant("ack1", 2);
        step(0, 4'b0110, 1, 1);
        exp_grant("ack2", 1);

        // round-robin fairness and wrap
        step(1, 4'b0000, 1, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 4'b1111, 1, 1);
            exp_grant("rr_all", rr_seq[i]);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 4'b1001, 1, 1);
            exp_grant("rr_wrap", wr_seq[i]);
        end

        // withdrawal without ack keeps ptr
        step(1, 4'b0000, 1, 0);
        step(0, 4'b0100, 1, 0);
        exp_grant("wd_grant", 2);
        step(0, 4'b0001, 1, 0);
        exp_grant("wd_rearb", 0);
        step(0, 4'b0000, 1, 0);
        exp_idle("wd_idle");
        step(0, 4'b1111, 1, 0);
        exp_grant("wd_ptr0", 0);

        // mode toggle while held, ack while idle
        step(1, 4'b0000, 1, 0);
        step(0, 4'b0010, 1, 0);
        exp_grant("ms_grant", 1);
        step(0, 4'b0011, 0, 0);
        exp_grant("ms_fixed_hold", 1);
        step(0, 4'b0011, 1, 0);
        exp_grant("ms_rr_hold", 1);
        step(0, 4'b0000, 1, 0);
        exp_idle("idle");
        step(0, 4'b0000, 1, 1);
        exp_idle("idle_ack");
        step(0, 4'b1111, 1, 0);
        exp_grant("idle_ack_ptr", 0);

        // random traffic
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 31) == 0), N'($urandom), 1'($urandom), 1'($urandom));
            chk("inv_oh", 64'(gnt_oh), valid ? 64'(N'(1) << gnt_idx) : 64'd0);
            chk("inv_range", 64'(int'(gnt_idx) < N), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/prio_arb_rr.md
# prio_arb_rr

Parametrised registered arbiter that generalises the team's 4-bit registered priority encoder. It adds N-wide requests, a runtime-selectable fixed-priority or round-robin mode, and a grant-hold/ack handshake. It sits between N requesters and a single shared resource. Each cycle it publishes one registered grant (index, one-hot and valid) and keeps that grant until the consumer acknowledges it or the requester withdraws.

## Interface
Parameters:
- N, default 4: number of request lines; legal range 2..64; need not be a power of two.
- IW, default $clog2(N): width of the grant index; derived, never overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- req  input  N  request vector; bit i set means requester i wants the resource.
- mode  input  1  0 = fixed priority, 1 = round-robin.
- ack  input  1  consumer accepts the current grant; ignored while valid = 0.
- gnt_idx  output  IW  index of the granted requester; registered.
- gnt_oh  output  N  one-hot grant, equal to 1 << gnt_idx when valid = 1, otherwise 0; registered.
- valid  output  1  a grant is present; registered.

## Operation
- Internal state: `ptr` (IW bits), the round-robin start position, plus the three output registers.
- Each rising edge (with rst = 0) takes exactly one of three actions:
  - **HOLD**, when valid = 1, ack = 0 and req[gnt_idx] = 1: all outputs keep their values and ptr is unchanged.
  - **RELEASE**, when valid = 1 and ack = 1: ptr <= (gnt_idx + 1) mod N, then arbitrate from start = (gnt_idx + 1) mod N.
  - **ARBITRATE**, in every other case, from start = ptr. This covers valid = 0, and also a requester that drops req before being acked; that grant is abandoned and ptr is unchanged.
- Arbitration function:
  - mode = 0: winner is the lowest set index of req. `start` is ignored, and bit 0 has the highest priority.
  - mode = 1: winner is the first set bit scanning start, start+1, … N-1, 0, … start-1, with wrap modulo N. For non-power-of-two N, index N-1 wraps to 0; no out-of-range index is ever produced.
  - req = 0: valid <= 0, gnt_oh <= 0, gnt_idx <= 0.
  - Otherwise: valid <= 1 and gnt_idx/gnt_oh get the winner.
- ptr is updated only by RELEASE, in both modes. Switching mode never clears ptr.
- A mode change takes effect at the next ARBITRATE/RELEASE. It does not break a grant that is being held.
- ack with valid = 0 has no effect.
- ack and a req drop in the same cycle are treated as RELEASE.
- In fixed mode after a RELEASE, the same requester may win again immediately if its req is still set.
- Fixed mode starves by design. Round-robin guarantees a continuously requesting line is granted within N grants.

## Timing
- Reset (rst = 1 at an edge): valid = 0, gnt_oh = 0, gnt_idx = 0, ptr = 0. Reset overrides everything, including a held grant mid-operation.
- The first grant can appear at the first edge after rst deasserts, if req ≠ 0.
- Latency: req sampled at edge k is reflected on the outputs after edge k (one cycle). There is no combinational path from inputs to outputs.
- ack sampled at edge k with valid = 1: the next grant, or valid = 0, is visible after edge k. A back-to-back grant every cycle is possible.
- Held grant: outputs are stable for as long as ack = 0 and the granted req stays high. The consumer may take any number of cycles.
- Requester withdrawal: withdrawing req[gnt_idx] without ack causes re-arbitration one cycle later. No ptr advance happens.

## Test plan
All scenarios use N = 4.
1. **Reset.** rst = 1 for 2 cycles with req = 4'b1111 → valid = 0, gnt_oh = 0, gnt_idx = 0. Assert rst at edge 3 while a grant is held → outputs return to 0 after that edge.
2. **Fixed priority, legacy patterns.** mode = 0, ack = 1 each cycle. Apply req = 1000, 1100, 0100, 1010, 1110, 1111, 0111, 0011, 0000 → gnt_idx = 3, 2, 2, 1, 1, 0, 0, 0, and finally valid = 0. Check gnt_oh matches gnt_idx.
3. **Hold/ack.** mode = 1, req = 0110, ack = 0 for 5 cycles → gnt_idx = 1 stable and ptr = 0. Then ack = 1 for 1 cycle → gnt_idx = 2 next cycle. ack again → gnt_idx = 1.
4. **Round-robin fairness and wrap.** mode = 1, req = 1111, ack = 1 continuously → gnt_idx sequence 0, 1, 2, 3, 0, 1. Then req = 1001 starting from ptr = 2 → grants 3, 0, 3, 0.
5. **Withdrawal.** mode = 1, grant on idx 2 (req = 0100) with ack = 0; change req to 0001 → next cycle gnt_idx = 0, and ptr is still 0, so the next RR search starts at 0.
6. **Mode switch and ack while idle.** Hold a grant on idx 1 and toggle mode 1 → 0 → grant held. ack while valid = 0 → no ptr change. Repeat with random req/ack for 200 cycles, checking the one-hot invariant and that gnt_idx < N.
